pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the myCPU five-stage pipeline. It generalises the fixed ID/EX register into one block that can sit between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a valid bit, a configurable payload, the instruction PC and the delay-slot flag. Its stall, bubble and flush rules follow the global 6-bit `stall` vector from `ctrl`.

## Interface
Parameters:
- `DATA_W`, default 128: payload width in bits (aluop, alusel, operands, wd, wreg, inst, link address, and so on, packed by the instantiating stage).
- `NOP_VALUE`, default `{DATA_W{1'b0}}`: payload driven when the stage is empty, flushed or bubbled.
- `STAGE`, default 2: index of the upstream stage in `stall`; valid range 0..`STALL_W`-1.
- `STALL_W`, default 6: width of the stall vector.
- `CNT_W`, default 16: width of the performance counters.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset (`RstEnable` = 1'b1).
- `stall`, input, `STALL_W`: global stall vector from `ctrl`.
- `flush`, input, 1: kill the stage contents (exception or redirect).
- `in_valid`, input, 1: upstream holds a real instruction.
- `in_data`, input, `DATA_W`: upstream payload.
- `in_pc`, input, 32: upstream instruction address.
- `in_dslot`, input, 1: upstream instruction is in a delay slot.
- `next_in_dslot_i`, input, 1: the next instruction entering upstream is a delay slot.
- `out_valid`, output, 1: downstream holds a real instruction.
- `out_data`, output, `DATA_W`: registered payload.
- `out_pc`, output, 32: registered PC.
- `out_dslot`, output, 1: registered delay-slot flag of the current downstream instruction.
- `dslot_fb_o`, output, 1: registered `next_in_dslot_i`, fed back to the upstream stage.
- `bubble_o`, output, 1: high for the cycle after a bubble was inserted.
- `hold_cnt_o`, output, `CNT_W`: performance counter (see Configuration).
- `bubble_cnt_o`, output, `CNT_W`: performance counter (see Configuration).

## Operation
- Define `up_stall = stall[STAGE]`.
- Define `dn_stall = stall[STAGE+1]`; when `STAGE == STALL_W-1`, `dn_stall` is constant 0.
- Each rising edge, the first matching rule applies:
  1. `rst`: `out_valid`=0, `out_data`=`NOP_VALUE`, `out_pc`=0, `out_dslot`=0, `dslot_fb_o`=0, `bubble_o`=0, counters=0.
  2. `flush`: `out_valid`=0, `out_data`=`NOP_VALUE`, `out_pc`=0, `out_dslot`=0, `dslot_fb_o`=0, `bubble_o`=0. `flush` overrides any stall.
  3. Bubble (`up_stall`=1 and `dn_stall`=0): `out_valid`=0, `out_data`=`NOP_VALUE`, `out_pc`=0, `out_dslot`=0, `bubble_o`=1. `dslot_fb_o` keeps its value.
  4. Advance (`up_stall`=0): `out_valid`=`in_valid`, `out_dslot`=`in_valid & in_dslot`, `bubble_o`=0.
     - If `in_valid`=1: `out_data`=`in_data`, `out_pc`=`in_pc`, `dslot_fb_o`=`next_in_dslot_i`.
     - If `in_valid`=0: `out_data`=`NOP_VALUE`, `out_pc`=0, `dslot_fb_o` unchanged.
  5. Hold (`up_stall`=1 and `dn_stall`=1): every output, including `out_pc`, keeps its value and `bubble_o`=0. `out_pc` is never updated while held.
- The stage state is derived, with no separate FSM register: EMPTY (`out_valid`=0), FULL (`out_valid`=1 and not held), HELD (`out_valid`=1 and `dn_stall`=1).
- A `stall` vector with `up_stall`=0 and `dn_stall`=1 is illegal; `ctrl` never produces it. The block treats it as Advance, and the bench flags it with an assertion.

## Timing
- Latency is 1 cycle from input to output; all outputs are registered and there are no combinational paths from input to output.
- `flush` and `rst` take effect on the same edge they are sampled; the first clean output appears 1 cycle later.
- `bubble_o` is a single-cycle pulse per bubble edge. During a multi-cycle upstream stall with `dn_stall`=0, it stays high on every such cycle.
- Reset asserted mid-stall or mid-flush dominates; the state after reset is independent of `stall` and `flush`.

## Configuration
- Macro: `PIPE_STAGE_PERF_CNT_EN`.
- Defined:
  - `hold_cnt_o` increments on each Hold edge while `out_valid`=1.
  - `bubble_cnt_o` increments on each Bubble edge.
  - Both saturate at 2^`CNT_W`-1, clear only on `rst`, and are unaffected by `flush`.
- Undefined: both counters are constant 0, with no counter flops synthesised. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 and `in_data`=0xA5.. → `out_valid`=0, `out_data`=`NOP_VALUE`, `out_pc`=0, counters=0.
- Streaming: `stall`=0, PCs 0xBFC00000, 0xBFC00004, 0xBFC00008 fed on consecutive cycles → the same PCs appear on `out_pc` one cycle later, with `out_valid`=1 each cycle.
- Load-use bubble: `stall`=6'b000111 for 1 cycle with `STAGE`=2 → next cycle `out_valid`=0, `out_data`=`NOP_VALUE`, `bubble_o`=1. The previous `dslot_fb_o` is retained, and `bubble_cnt_o`=1 when the macro is defined.
- Full hold: `stall`=6'b001111 for 3 cycles while `out_pc`=0x100 → `out_pc` stays 0x100 and `out_valid` stays 1. `hold_cnt_o`=3 with the macro and 0 without it.
- Flush over stall: `flush`=1 and `stall`=6'b001111 in the same cycle → next cycle `out_valid`=0, `out_dslot`=0, `dslot_fb_o`=0.
- Delay slot: a branch with `next_in_dslot_i`=1 advances → `dslot_fb_o`=1. The following instruction advances with `in_dslot`=1 → `out_dslot`=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with stall/bubble/flush handling
// Optional macro PIPE_STAGE_PERF_CNT_EN enables the hold and bubble performance counters.
module pipe_stage_reg #(
  parameter int                DATA_W    = 128,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                STAGE     = 2,
  parameter int                STALL_W   = 6,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [31:0]        in_pc,
  input  logic               in_dslot,
  input  logic               next_in_dslot_i,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [31:0]        out_pc,
  output logic               out_dslot,
  output logic               dslot_fb_o,
  output logic               bubble_o,
  output logic [CNT_W-1:0]   hold_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  logic up_stall;
  logic dn_stall;

  assign up_stall = stall[STAGE];

  // The last stage has no downstream stall bit, so it can never be held.
  generate
    if (STAGE >= STALL_W - 1) begin : g_last_stage
      assign dn_stall = 1'b0;
    end else begin : g_mid_stage
      assign dn_stall = stall[STAGE+1];
    end
  endgenerate

  logic do_bubble;
  logic do_hold;

  assign do_bubble = up_stall & ~dn_stall;
  assign do_hold   = up_stall &  dn_stall;

  // Stage register: reset, flush, bubble, advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= NOP_VALUE;
      out_pc     <= 32'h0;
      out_dslot  <= 1'b0;
      dslot_fb_o <= 1'b0;
      bubble_o   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_data   <= NOP_VALUE;
      out_pc     <= 32'h0;
      out_dslot  <= 1'b0;
      dslot_fb_o <= 1'b0;
      bubble_o   <= 1'b0;
    end else if (do_bubble) begin
      out_valid  <= 1'b0;
      out_data   <= NOP_VALUE;
      out_pc     <= 32'h0;
      out_dslot  <= 1'b0;
      bubble_o   <= 1'b1;
    end else if (!up_stall) begin
      // An up_stall=0/dn_stall=1 vector is illegal and simply advances here.
      out_valid <= in_valid;
      out_dslot <= in_valid & in_dslot;
      bubble_o  <= 1'b0;
      if (in_valid) begin
        out_data   <= in_data;
        out_pc     <= in_pc;
        dslot_fb_o <= next_in_dslot_i;
      end else begin
        out_data <= NOP_VALUE;
        out_pc   <= 32'h0;
      end
    end else begin
      bubble_o <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  // Saturating counters; flush edges are neither hold nor bubble edges and leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      bubble_cnt <= '0;
    end else if (!flush) begin
      if (do_hold && out_valid && hold_cnt != {CNT_W{1'b1}}) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (do_bubble && bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

  assign hold_cnt_o   = hold_cnt;
  assign bubble_cnt_o = bubble_cnt;
`else
  assign hold_cnt_o   = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule
